// File: rtl/yuv2rgb_pkg.sv
// Shared types and constants for the YUV 4:4:4 to RGB frame converter.
package yuv2rgb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_Y,
    ST_RD_U,
    ST_RD_V,
    ST_CAP_V,
    ST_CALC,
    ST_WR_R,
    ST_WR_G,
    ST_WR_B,
    ST_DONE
  } state_e;

  localparam int unsigned COEF_W = 18;
  localparam int unsigned ACC_W  = 28;
  localparam int unsigned FRAC   = 16;
  localparam int unsigned ROUND  = 32768;

  localparam logic [7:0] Y_OFFSET  = 8'd16;
  localparam logic [7:0] UV_OFFSET = 8'd128;

  typedef struct packed {
    logic [COEF_W-1:0] cy;
    logic [COEF_W-1:0] crv;
    logic [COEF_W-1:0] cgu;
    logic [COEF_W-1:0] cgv;
    logic [COEF_W-1:0] cbu;
  } coef_t;

  localparam coef_t COEF_STUDIO = '{cy: 18'd76284, crv: 18'd104595, cgu: 18'd25624,
                                    cgv: 18'd53281, cbu: 18'd132251};
  localparam coef_t COEF_FULL   = '{cy: 18'd65536, crv: 18'd91881, cgu: 18'd22554,
                                    cgv: 18'd46802, cbu: 18'd116130};

  // Round to nearest, then drop the 16 fractional bits (floor on negatives).
  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] sum;
    sum = x + $signed(ACC_W'(ROUND));
    return sum >>> FRAC;
  endfunction

  function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] x);
    if (x[ACC_W-1]) return 8'd0;
    else if (x[ACC_W-1:8] != '0) return 8'hFF;
    else return x[7:0];
  endfunction

endpackage

// File: rtl/yuv2rgb_frame_converter_if.sv
// Control handshake and frame-memory port of the converter.
interface yuv2rgb_frame_converter_if #(
  parameter int unsigned ADDR_W = 20
) ();
  logic              start;
  logic              full_range;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] R_addr;
  logic [15:0]       R_data;
  logic [ADDR_W-1:0] W_addr;
  logic [15:0]       W_data;
  logic              W_en;

  modport master (
    input  start, full_range, R_data,
    output busy, done, R_addr, W_addr, W_data, W_en
  );

  modport slave (
    output start, full_range, R_data,
    input  busy, done, R_addr, W_addr, W_data, W_en
  );
endinterface

// File: rtl/yuv_rgb_pixel.sv
// One-pixel BT.601 YUV to RGB conversion, 16.16 fixed point, saturating.
module yuv_rgb_pixel
  import yuv2rgb_pkg::*;
(
  input  logic [7:0] y_i,
  input  logic [7:0] u_i,
  input  logic [7:0] v_i,
  input  logic       full_range,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o
);

  coef_t                   c;
  logic signed [ACC_W-1:0] y_s, u_s, v_s;
  logic signed [ACC_W-1:0] r_acc, g_acc, b_acc;

  function automatic logic signed [ACC_W-1:0] zx8(input logic [7:0] x);
    return $signed({{(ACC_W-8){1'b0}}, x});
  endfunction

  function automatic logic signed [ACC_W-1:0] zx18(input logic [COEF_W-1:0] x);
    return $signed({{(ACC_W-COEF_W){1'b0}}, x});
  endfunction

  always_comb begin
    c     = full_range ? COEF_FULL : COEF_STUDIO;
    y_s   = full_range ? zx8(y_i) : zx8(y_i) - zx8(Y_OFFSET);
    u_s   = zx8(u_i) - zx8(UV_OFFSET);
    v_s   = zx8(v_i) - zx8(UV_OFFSET);
    r_acc = zx18(c.cy) * y_s + zx18(c.crv) * v_s;
    g_acc = zx18(c.cy) * y_s - zx18(c.cgu) * u_s - zx18(c.cgv) * v_s;
    b_acc = zx18(c.cy) * y_s + zx18(c.cbu) * u_s;
    r_o   = sat8(round_shift(r_acc));
    g_o   = sat8(round_shift(g_acc));
    b_o   = sat8(round_shift(b_acc));
  end

endmodule

// File: rtl/yuv2rgb_frame_converter.sv
// Walks planar Y/U/V word planes and writes planar R/G/B planes, 8 cycles per word.
module yuv2rgb_frame_converter
  import yuv2rgb_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 38400,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned Y_BASE    = 0,
  parameter int unsigned U_BASE    = 38400,
  parameter int unsigned V_BASE    = 76800,
  parameter int unsigned R_BASE    = 115200,
  parameter int unsigned G_BASE    = 153600,
  parameter int unsigned B_BASE    = 192000
) (
  input  logic                      clk,
  input  logic                      rst,
  yuv2rgb_frame_converter_if.master bus
);

  localparam int unsigned     IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mode_q, mode_d;
  logic [15:0]       y_q, y_d, u_q, u_d, v_q, v_d, g_q, g_d, b_q, b_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d;
  logic [15:0]       w_data_q, w_data_d;
  logic              w_en_q, w_en_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]        r_even_c, g_even_c, b_even_c, r_odd_c, g_odd_c, b_odd_c;

  yuv_rgb_pixel u_pix_even (
    .y_i(y_q[7:0]), .u_i(u_q[7:0]), .v_i(v_q[7:0]), .full_range(mode_q),
    .r_o(r_even_c), .g_o(g_even_c), .b_o(b_even_c)
  );

  yuv_rgb_pixel u_pix_odd (
    .y_i(y_q[15:8]), .u_i(u_q[15:8]), .v_i(v_q[15:8]), .full_range(mode_q),
    .r_o(r_odd_c), .g_o(g_odd_c), .b_o(b_odd_c)
  );

  function automatic logic [ADDR_W-1:0] plane_addr(input int unsigned base,
                                                   input logic [IDX_W-1:0] i);
    return ADDR_W'(base) + ADDR_W'(i);
  endfunction

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    y_d      = y_q;
    u_d      = u_q;
    v_d      = v_q;
    g_d      = g_q;
    b_d      = b_q;
    r_addr_d = '0;
    w_addr_d = '0;
    w_data_d = '0;
    w_en_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.full_range;
          idx_d   = '0;
          state_d = ST_RD_Y;
        end
      end
      ST_RD_Y:  state_d = ST_RD_U;
      ST_RD_U:  begin y_d = bus.R_data; state_d = ST_RD_V;  end
      ST_RD_V:  begin u_d = bus.R_data; state_d = ST_CAP_V; end
      ST_CAP_V: begin v_d = bus.R_data; state_d = ST_CALC;  end
      ST_CALC: begin
        g_d     = {g_odd_c, g_even_c};
        b_d     = {b_odd_c, b_even_c};
        state_d = ST_WR_R;
      end
      ST_WR_R:  state_d = ST_WR_G;
      ST_WR_G:  state_d = ST_WR_B;
      ST_WR_B: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_RD_Y;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);

    // The R word is registered straight into the write-data flop during CALC.
    case (state_d)
      ST_RD_Y: r_addr_d = plane_addr(Y_BASE, idx_d);
      ST_RD_U: r_addr_d = plane_addr(U_BASE, idx_d);
      ST_RD_V: r_addr_d = plane_addr(V_BASE, idx_d);
      ST_WR_R: begin
        w_en_d   = 1'b1;
        w_addr_d = plane_addr(R_BASE, idx_d);
        w_data_d = {r_odd_c, r_even_c};
      end
      ST_WR_G: begin
        w_en_d   = 1'b1;
        w_addr_d = plane_addr(G_BASE, idx_d);
        w_data_d = g_q;
      end
      ST_WR_B: begin
        w_en_d   = 1'b1;
        w_addr_d = plane_addr(B_BASE, idx_d);
        w_data_d = b_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      mode_q   <= 1'b0;
      y_q      <= '0;
      u_q      <= '0;
      v_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      r_addr_q <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_en_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      y_q      <= y_d;
      u_q      <= u_d;
      v_q      <= v_d;
      g_q      <= g_d;
      b_q      <= b_d;
      r_addr_q <= r_addr_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_en_q   <= w_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.R_addr = r_addr_q;
  assign bus.W_addr = w_addr_q;
  assign bus.W_data = w_data_q;
  assign bus.W_en   = w_en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_yuv2rgb_frame_converter.sv
// Self-checking bench: directed and random frames against an arithmetic reference model.
module tb_yuv2rgb_frame_converter;

  localparam int NW = 4;
  localparam int AW = 8;
  localparam int YB = 8;
  localparam int UB = 24;
  localparam int VB = 40;
  localparam int RB = 56;
  localparam int GB = 72;
  localparam int BB = 88;

  logic clk = 1'b0;
  logic rst;

  yuv2rgb_frame_converter_if #(.ADDR_W(AW)) bus ();

  yuv2rgb_frame_converter #(
    .NUM_WORDS(NW), .ADDR_W(AW), .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB),
    .R_BASE(RB), .G_BASE(GB), .B_BASE(BB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0]   yp [NW];
  logic [15:0]   up [NW];
  logic [15:0]   vp [NW];
  logic [AW-1:0] wa_q [$];
  logic [15:0]   wd_q [$];
  int            done_cnt = 0;
  int            n_pass   = 0;
  int            n_total  = 0;

  function automatic logic [15:0] rd(input logic [AW-1:0] a);
    int ai;
    ai = int'(a);
    if (ai >= YB && ai < YB + NW) return yp[ai - YB];
    if (ai >= UB && ai < UB + NW) return up[ai - UB];
    if (ai >= VB && ai < VB + NW) return vp[ai - VB];
    return 16'hDEAD;
  endfunction

  // Synchronous frame memory and write/done logger.
  always @(posedge clk) begin
    bus.R_data <= rd(bus.R_addr);
    if (bus.W_en) begin
      wa_q.push_back(bus.W_addr);
      wd_q.push_back(bus.W_data);
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  function automatic int clampi(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  function automatic int ref_pix(input int yv, input int uv, input int vv, input bit fr,
                                 input int ch);
    int y, u, v, cy, crv, cgu, cgv, cbu, acc;
    y   = fr ? yv : yv - 16;
    u   = uv - 128;
    v   = vv - 128;
    cy  = fr ? 65536  : 76284;
    crv = fr ? 91881  : 104595;
    cgu = fr ? 22554  : 25624;
    cgv = fr ? 46802  : 53281;
    cbu = fr ? 116130 : 132251;
    if (ch == 0)      acc = cy * y + crv * v;
    else if (ch == 1) acc = cy * y - cgu * u - cgv * v;
    else              acc = cy * y + cbu * u;
    return clampi((acc + 32768) >>> 16);
  endfunction

  function automatic logic [15:0] exp_word(input int w, input int ch, input bit fr);
    logic [15:0] r;
    r[7:0]  = 8'(ref_pix(int'(yp[w][7:0]),  int'(up[w][7:0]),  int'(vp[w][7:0]),  fr, ch));
    r[15:8] = 8'(ref_pix(int'(yp[w][15:8]), int'(up[w][15:8]), int'(vp[w][15:8]), fr, ch));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic fill_const(input logic [15:0] y, input logic [15:0] u, input logic [15:0] v);
    for (int i = 0; i < NW; i++) begin
      yp[i] = y; up[i] = u; vp[i] = v;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NW; i++) begin
      yp[i] = 16'($urandom); up[i] = 16'($urandom); vp[i] = 16'($urandom);
    end
  endtask

  task automatic check_frame(input int base, input bit fr, input string tag);
    int w, ch, pb;
    chk({tag, "_nwrites"}, 32'(wa_q.size() - base), 32'(3 * NW));
    for (int j = 0; j < 3 * NW && base + j < wa_q.size(); j++) begin
      w  = j / 3;
      ch = j % 3;
      pb = (ch == 0) ? RB : ((ch == 1) ? GB : BB);
      chk($sformatf("%s_addr%0d", tag, j), 32'(wa_q[base + j]), 32'(pb + w));
      chk($sformatf("%s_data%0d", tag, j), 32'(wd_q[base + j]), 32'(exp_word(w, ch, fr)));
    end
  endtask

  // Start a frame and wait (bounded) for done; returns latency and first read address.
  task automatic run_frame(input bit fr, input bit disturb, output int lat, output int ra1);
    lat = -1;
    ra1 = -1;
    @(negedge clk);
    bus.full_range = fr;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n < 200; n++) begin
      if (n == 1) ra1 = int'(bus.R_addr);
      if (disturb && (n == 5 || n == 11 || n == 17)) bus.full_range = ~bus.full_range;
      if (disturb && (n == 5 || n == 17)) bus.start = 1'b1;
      if (disturb && (n == 6 || n == 18)) bus.start = 1'b0;
      if (bus.done) begin
        lat = n;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.start      = 1'b0;
    bus.full_range = 1'b0;
  endtask

  initial begin
    int  lat, ra1, base, nb, n;
    bit  fr;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.full_range = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_w_en",   32'(bus.W_en),   32'd0);
    chk("rst_r_addr", 32'(bus.R_addr), 32'd0);
    chk("rst_w_addr", 32'(bus.W_addr), 32'd0);
    chk("rst_w_data", 32'(bus.W_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Studio black: every output word zero.
    fill_const(16'h1010, 16'h8080, 16'h8080);
    base = wa_q.size(); nb = done_cnt;
    run_frame(1'b0, 1'b0, lat, ra1);
    chk("a_latency", 32'(lat), 32'd33);
    chk("a_first_raddr", 32'(ra1), 32'(YB));
    chk("a_done_pulse", 32'(bus.done), 32'd0);
    chk("a_idle_busy", 32'(bus.busy), 32'd0);
    chk("a_done_count", 32'(done_cnt - nb), 32'd1);
    check_frame(base, 1'b0, "a");
    if (wd_q.size() > base) chk("a_zero_word", 32'(wd_q[base]), 32'd0);

    // Studio white odd / black even.
    fill_const(16'hEB10, 16'h8080, 16'h8080);
    base = wa_q.size();
    run_frame(1'b0, 1'b0, lat, ra1);
    check_frame(base, 1'b0, "b");
    if (wd_q.size() >= base + 3) begin
      chk("b_r_word", 32'(wd_q[base]),     32'h0000FF00);
      chk("b_g_word", 32'(wd_q[base + 1]), 32'h0000FF00);
      chk("b_b_word", 32'(wd_q[base + 2]), 32'h0000FF00);
    end

    // Clipping: even pixel drives R below 0, odd pixel above 255.
    fill_const(16'hFF00, 16'h8080, 16'hFF00);
    base = wa_q.size();
    run_frame(1'b0, 1'b0, lat, ra1);
    check_frame(base, 1'b0, "c");
    if (wd_q.size() > base) chk("c_r_clip", 32'(wd_q[base]), 32'h0000FF00);

    // Full range grey and saturated-V word.
    fill_rand();
    yp[0] = 16'h6464; up[0] = 16'h8080; vp[0] = 16'h8080;
    yp[1] = 16'h0000; up[1] = 16'h8080; vp[1] = 16'hFFFF;
    base = wa_q.size();
    run_frame(1'b1, 1'b0, lat, ra1);
    chk("d_latency", 32'(lat), 32'd33);
    check_frame(base, 1'b1, "d");
    if (wd_q.size() >= base + 6) begin
      chk("d_r_grey", 32'(wd_q[base]),     32'h00006464);
      chk("d_g_grey", 32'(wd_q[base + 1]), 32'h00006464);
      chk("d_b_grey", 32'(wd_q[base + 2]), 32'h00006464);
      chk("d_r_v255", 32'(wd_q[base + 3]), 32'h0000B2B2);
      chk("d_g_v255", 32'(wd_q[base + 4]), 32'h00000000);
      chk("d_b_v255", 32'(wd_q[base + 5]), 32'h00000000);
    end

    // Random frames in random mode.
    for (int k = 0; k < 3; k++) begin
      fill_rand();
      fr = 1'($urandom);
      base = wa_q.size();
      run_frame(fr, 1'b0, lat, ra1);
      chk($sformatf("e%0d_latency", k), 32'(lat), 32'd33);
      check_frame(base, fr, $sformatf("e%0d", k));
    end

    // Start and mode toggles while busy must not disturb the frame.
    fill_rand();
    base = wa_q.size(); nb = done_cnt;
    run_frame(1'b0, 1'b1, lat, ra1);
    chk("f_latency", 32'(lat), 32'd33);
    check_frame(base, 1'b0, "f");
    repeat (12) @(negedge clk);
    chk("f_done_count", 32'(done_cnt - nb), 32'd1);
    chk("f_total_writes", 32'(wa_q.size() - base), 32'(3 * NW));

    // Reset during WR_G of word 2 abandons the frame.
    fill_rand();
    base = wa_q.size();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!(bus.W_en && bus.W_addr == AW'(GB + 2)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("g_reached_wr_g", 32'(n < 100), 32'd1);
    rst = 1'b0;
    #1;
    chk("g_rst_w_en",   32'(bus.W_en),   32'd0);
    chk("g_rst_busy",   32'(bus.busy),   32'd0);
    chk("g_rst_w_addr", 32'(bus.W_addr), 32'd0);
    chk("g_rst_w_data", 32'(bus.W_data), 32'd0);
    chk("g_rst_r_addr", 32'(bus.R_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("g_writes_before_rst", 32'(wa_q.size() - base), 32'd7);
    fill_rand();
    base = wa_q.size();
    run_frame(1'b0, 1'b0, lat, ra1);
    chk("g_restart_latency", 32'(lat), 32'd33);
    chk("g_restart_raddr", 32'(ra1), 32'(YB));
    check_frame(base, 1'b0, "g");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
